// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub round-robin arbiter.
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
  localparam int OPERAND_W = 8;
  localparam int SUM_W     = 9;
  localparam int SAT_MAX   = 127;
  localparam int SAT_MIN   = -128;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;

  // Walk from the farthest slot inwards so the nearest hit after ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sequencer sharing one external 8-bit add/sub among N_REQ requesters.
// Optional ADDSUB_SAT_EN: clamps the result to 8-bit signed range and adds rsp_sat.
module addsub_rr_arbiter
  import addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*OPERAND_W-1:0] req_a,
  input  logic [N_REQ*OPERAND_W-1:0] req_b,
  input  logic [N_REQ-1:0]           req_sub,
  output logic [OPERAND_W-1:0]       add_a,
  output logic [OPERAND_W-1:0]       add_b,
  output logic                       add_sub,
  input  logic [SUM_W-1:0]           add_sum,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SUM_W-1:0]           rsp_sum,
  output logic [ID_W-1:0]            rsp_id,
`ifdef ADDSUB_SAT_EN
  output logic                       rsp_sat,
`endif
  output logic                       busy
);
  arb_state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]      r_ptr, r_id, w_idx;
  logic [OPERAND_W-1:0] r_a, r_b;
  logic                 r_sub, r_rsp_valid, w_any, w_accept;
  logic [SUM_W-1:0]     r_rsp_sum;
  logic [N_REQ-1:0]     w_grant;
`ifdef ADDSUB_SAT_EN
  logic                 r_sat;
`endif

  rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
    .req(req_valid), .ptr(r_ptr), .grant(w_grant), .idx(w_idx), .any(w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_any) w_state_nxt = EXEC;
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= ID_W'(N_REQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
`ifdef ADDSUB_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= req_a[w_idx*OPERAND_W +: OPERAND_W];
        r_b   <= req_b[w_idx*OPERAND_W +: OPERAND_W];
        r_sub <= req_sub[w_idx];
        r_ptr <= w_idx;
        r_id  <= w_idx;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
`ifdef ADDSUB_SAT_EN
        if ($signed(add_sum) > SAT_MAX) begin
          r_rsp_sum <= SUM_W'(SAT_MAX);
          r_sat     <= 1'b1;
        end else if ($signed(add_sum) < SAT_MIN) begin
          r_rsp_sum <= SUM_W'(SAT_MIN);
          r_sat     <= 1'b1;
        end else begin
          r_rsp_sum <= add_sum;
          r_sat     <= 1'b0;
        end
`else
        r_rsp_sum <= add_sum;
`endif
      end else if (r_state == RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign add_a     = r_a;
  assign add_b     = r_b;
  assign add_sub   = r_sub;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);
`ifdef ADDSUB_SAT_EN
  assign rsp_sat   = r_sat;
`endif
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Randomized self-checking bench for addsub_rr_arbiter against a transaction-level model.
module tb_addsub_rr_arbiter;
  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_sub = '0;
  logic [N*8-1:0] req_a = '0, req_b = '0;
  logic [7:0] add_a, add_b;
  logic add_sub, rsp_valid, rsp_ready = 1'b0, busy;
  logic [8:0] add_sum, rsp_sum;
  logic [IW-1:0] rsp_id;
`ifdef ADDSUB_SAT_EN
  logic rsp_sat;
`endif

  always #5 clk = ~clk;

  // Shared adder that lives next to the block at ALU top level.
  assign add_sum = add_sub ? ({add_a[7], add_a} - {add_b[7], add_b})
                           : ({add_a[7], add_a} + {add_b[7], add_b});

  addsub_rr_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
`ifdef ADDSUB_SAT_EN
    .rsp_sat(rsp_sat),
`endif
    .busy(busy)
  );

  int n_chk = 0, n_err = 0;
  bit pend_v[N];
  int pend_a[N], pend_b[N];
  bit pend_s[N];
  bit rdy;
  // Model: pointer, op phase (0 idle, 1 computing, 2 result pending), result.
  int m_ptr, m_phase, m_sum, m_id;
  bit m_sat;
  int grants[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_op(input int i);
    int sel;
    sel = $urandom_range(0, 7);
    pend_v[i] = 1'b1;
    pend_s[i] = 1'($urandom_range(0, 1));
    pend_a[i] = (sel == 0) ? -128 : (sel == 1) ? 127 : int'($urandom_range(0, 255)) - 128;
    pend_b[i] = (sel == 0) ? 127 : (sel == 1) ? -128 : int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic model_reset();
    m_ptr = N - 1; m_phase = 0; m_sum = 0; m_id = 0; m_sat = 0;
  endtask

  // One clock cycle: drive at negedge, check, then apply the model at posedge.
  task automatic step();
    int g, j, r;
    logic [7:0] t;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend_v[i];
      req_sub[i]   = pend_s[i];
      t = 8'(pend_a[i]); req_a[8*i +: 8] = t;
      t = 8'(pend_b[i]); req_b[8*i +: 8] = t;
    end
    rsp_ready = rdy;
    #1;
    g = -1;
    if (m_phase == 0)
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (pend_v[j] && g < 0) g = j;
      end
    chk("req_ready", int'(req_ready), g >= 0 ? (1 << g) : 0);
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("rsp_valid", int'(rsp_valid), int'(m_phase == 2));
    if (m_phase == 2) begin
      chk("rsp_sum", int'($signed(rsp_sum)), m_sum);
      chk("rsp_id", int'(rsp_id), m_id);
`ifdef ADDSUB_SAT_EN
      chk("rsp_sat", int'(rsp_sat), int'(m_sat));
`endif
    end
    @(posedge clk);
    if (g >= 0) begin
      r = pend_s[g] ? pend_a[g] - pend_b[g] : pend_a[g] + pend_b[g];
      m_sat = 0;
`ifdef ADDSUB_SAT_EN
      if (r > 127) begin r = 127; m_sat = 1; end
      else if (r < -128) begin r = -128; m_sat = 1; end
`endif
      m_sum = r; m_id = g; m_ptr = g; m_phase = 1;
      pend_v[g] = 1'b0;
      grants.push_back(g);
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && rdy) m_phase = 0;
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b, input bit s);
    pend_v[i] = 1'b1; pend_a[i] = a; pend_b[i] = b; pend_s[i] = s;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_a[i] = 0; pend_b[i] = 0; pend_s[i] = 0; end
    rdy = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_sum", int'(rsp_sum), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_add_a", int'(add_a), 0);
    chk("rst_add_b", int'(add_b), 0);
    chk("rst_add_sub", int'(add_sub), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single op and extremes.
    set_op(0, 100, -50, 1'b1);
    repeat (4) step();
    set_op(1, -128, 127, 1'b1);
    repeat (4) step();
    set_op(2, -128, -128, 1'b0);
    repeat (4) step();
    set_op(3, 127, 127, 1'b0);
    repeat (4) step();

    // All requesters continuously valid: order must rotate.
    grants.delete();
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) new_op(i);
      step();
    end
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < grants.size(); i++) chk("rr_order", grants[i], (i) % N);
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    repeat (3) step();

    // Pointer skip: after req2, only req0/req1 valid.
    set_op(2, 5, 6, 1'b0);
    repeat (3) step();
    grants.delete();
    set_op(0, 1, 2, 1'b0);
    set_op(1, 3, 4, 1'b1);
    repeat (6) step();
    chk("skip_n", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("skip_first", grants[0], 0);
      chk("skip_second", grants[1], 1);
    end

    // Backpressure with req1 waiting.
    set_op(0, -77, 33, 1'b1);
    step();
    set_op(1, 12, -99, 1'b0);
    rdy = 1'b0;
    repeat (12) step();
    rdy = 1'b1;
    repeat (6) step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i] && $urandom_range(0, 3) == 0) new_op(i);
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    rdy = 1'b1;
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    repeat (4) step();

    // Asynchronous reset while a result is pending.
    set_op(3, 20, 22, 1'b0);
    rdy = 1'b0;
    for (int c = 0; c < 10 && m_phase != 2; c++) step();
    chk("reach_resp", int'(m_phase == 2), 1);
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rsp_sum", int'(rsp_sum), 0);
    chk("arst_rsp_id", int'(rsp_id), 0);
    chk("arst_add_a", int'(add_a), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rdy = 1'b1;
    grants.delete();
    for (int i = 0; i < N; i++) new_op(i);
    repeat (4) step();
    chk("post_rst_first", grants.size() > 0 ? grants[0] : -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 8-bit signed adder/subtractor between N_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake.
- Registers the operands and drives the shared adder.
- Captures the 9-bit sign-extended sum and returns it, tagged with the requester ID, over a valid/ready response channel.
- The adder is instantiated alongside this block at the ALU top level and connected through the add_* ports.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, $clog2(N_REQ), width of requester ID

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_a  in  N_REQ*8  packed signed operand A, requester i at [8i+7:8i]
req_b  in  N_REQ*8  packed signed operand B
req_sub  in  N_REQ  1 = A-B, 0 = A+B
add_a  out  8  operand A to shared adder
add_b  out  8  operand B to shared adder (uncomplemented; adder complements)
add_sub  out  1  subtract control to shared adder
add_sum  in  9  signed 9-bit result from shared adder
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_sum  out  9  registered signed result
rsp_id  out  ID_W  index of the requester that issued the op
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=N_REQ-1, operand regs=0, add_sub=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0. Reset is honoured in any state, aborting any in-flight op with no response issued.
- States:
  - IDLE: req_ready = grant vector, computed combinationally from req_valid and rr_ptr. Accept when any req_valid is set. Load add_a/add_b/add_sub from the granted slice, load the ID, set rr_ptr=granted index, go to EXEC.
  - EXEC: exactly one cycle. The adder settles from the registered operands. At the clock edge, rsp_sum<=add_sum and rsp_valid<=1; go to RESP.
  - RESP: hold rsp_sum/rsp_id stable. On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
- req_ready=0 in EXEC and RESP. Only one op is outstanding at a time.
- Latency: accept at edge T, rsp_valid high from T+2. Best-case throughput is one op per 3 cycles.
- Round-robin: search starts at (rr_ptr+1) mod N_REQ and wraps. The first requester with valid set wins. rr_ptr changes only on accept.
- A requester must hold req_valid and its operands until it is granted. The block never drops a granted op.
- rsp_ready held high: RESP lasts one cycle.
- rsp_ready low: result held indefinitely, and new requests stall.
- Arithmetic: add_sum is the full 9-bit sign-extended result, so no overflow is possible (range -256..+254 for the sum, -255..+255 for the difference).
- add_a/add_b/add_sub keep their last value outside EXEC. They are not cleared.

Optional Feature:
ADDSUB_SAT_EN
- Defined: adds output port rsp_sat (1 bit, reset 0). At EXEC capture, add_sum is clamped to -128..+127 and rsp_sat=1 whenever clamping occurs. rsp_sum keeps 9 bits but is always sign-extended from 8.
- Undefined: no rsp_sat port, and rsp_sum is add_sum unmodified.

Decomposition:
- Shared package addsub_pkg holds:
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t
  - localparam OPERAND_W=8, SUM_W=9
  - SAT_MAX=127, SAT_MIN=-128
- One sub-module: rr_pick (parameter N; inputs req[N], ptr; outputs grant one-hot, idx, any). It is purely combinational so the round-robin search can be verified in isolation.

Test Plan:
- Reset mid-op: assert rst during RESP with a valid result pending -> all outputs return to reset values immediately (asynchronously), rsp_valid=0, and the next accept is requester 0.
- Single op: req0 a=100, b=-50, sub=1, rsp_ready=1 -> req_ready[0]=1 at T, rsp_valid at T+2, rsp_sum=150 (9'h096), rsp_id=0.
- Round-robin fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with one grant every 3 cycles.
- Pointer wrap/skip: rr_ptr=2 after granting req2, then only req0 and req1 valid -> req0 granted, then req1.
- Backpressure: rsp_ready=0 for 10 cycles with req1 valid -> rsp_sum/rsp_id stable, req_ready=0 throughout, req1 granted the cycle after the handshake completes.
- Extremes: a=-128, b=127, sub=1 -> rsp_sum=-255 (9'h101). With ADDSUB_SAT_EN defined: rsp_sum=-128, rsp_sat=1.
